// File: rtl/serial_word_loader.sv
// serial_word_loader
//   Tick-paced serial-to-parallel receiver feeding the {d, en} inputs of an
//   enabled register. It assembles one framed word (start, DATA_W data bits
//   LSB first, optional parity, stop) and pulses load_en for one clk cycle with
//   the word on data. A low stop bit pulses frame_err and parks the FSM in
//   BREAK until the line returns high.
//
//   Optional feature macro: PARITY_CHK_EN adds an even-parity bit after the
//   data bits and the parity_err output.
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   asynchronous, active-high
//   tick        in   bit-rate strobe; rx is sampled only when tick=1
//   rx          in   serial line, idle high
//   data        out  last good word; changes only together with load_en
//   load_en     out  1-cycle pulse: data valid, load it
//   busy        out  1 whenever the receiver is not idle
//   frame_err   out  1-cycle pulse: stop bit sampled low
//   parity_err  out  (PARITY_CHK_EN only) pulses with load_en on odd parity
module serial_word_loader #(
   parameter int unsigned DATA_W = 7,
   parameter int unsigned CNT_W  = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              tick,
   input  logic              rx,
   output logic [DATA_W-1:0] data,
   output logic              load_en,
   output logic              busy,
`ifdef PARITY_CHK_EN
   output logic              parity_err,
`endif
   output logic              frame_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DATA,
`ifdef PARITY_CHK_EN
      S_PARITY,
`endif
      S_STOP,
      S_BREAK
   } state_t;

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              load_en_q, load_en_d;
   logic              frame_err_q, frame_err_d;
   logic              busy_q, busy_d;
`ifdef PARITY_CHK_EN
   logic              par_q, par_d;
   logic              perr_q, perr_d;
`endif

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         shift_q     <= '0;
         data_q      <= '0;
         load_en_q   <= 1'b0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
`ifdef PARITY_CHK_EN
         par_q       <= 1'b0;
         perr_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         load_en_q   <= load_en_d;
         frame_err_q <= frame_err_d;
         busy_q      <= busy_d;
`ifdef PARITY_CHK_EN
         par_q       <= par_d;
         perr_q      <= perr_d;
`endif
      end
   end

   // Next-state and output logic; nothing moves without a tick
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shift_d     = shift_q;
      data_d      = data_q;
      load_en_d   = 1'b0;
      frame_err_d = 1'b0;
`ifdef PARITY_CHK_EN
      par_d       = par_q;
      perr_d      = 1'b0;
`endif
      if (tick) begin
         case (state_q)
            S_IDLE: begin
               if (!rx) begin
                  state_d = S_DATA;
                  cnt_d   = '0;
               end
            end
            S_DATA: begin
               // LSB arrives first, so shifting right leaves it at bit 0
               shift_d = {rx, shift_q[DATA_W-1:1]};
               cnt_d   = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_BIT) begin
`ifdef PARITY_CHK_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end
`ifdef PARITY_CHK_EN
            S_PARITY: begin
               par_d   = rx;
               state_d = S_STOP;
            end
`endif
            S_STOP: begin
               if (rx) begin
                  data_d    = shift_q;
                  load_en_d = 1'b1;
`ifdef PARITY_CHK_EN
                  perr_d    = ^{shift_q, par_q};
`endif
                  state_d   = S_IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = S_BREAK;
               end
            end
            S_BREAK: begin
               if (rx) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
      busy_d = (state_d != S_IDLE);
   end

   assign data      = data_q;
   assign load_en   = load_en_q;
   assign frame_err = frame_err_q;
   assign busy      = busy_q;
`ifdef PARITY_CHK_EN
   assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_serial_word_loader.sv
// Testbench for serial_word_loader: frames are driven bit by bit; each frame's
// expected outcome is queued and a monitor checks every output pulse.
module tb_serial_word_loader;

   localparam int unsigned DATA_W = 7;

   logic              clk = 1'b0;
   logic              reset;
   logic              tick;
   logic              rx;
   logic [DATA_W-1:0] data;
   logic              load_en;
   logic              busy;
   logic              frame_err;
`ifdef PARITY_CHK_EN
   logic              parity_err;
`endif

   serial_word_loader #(.DATA_W(DATA_W), .CNT_W(3)) dut (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick),
      .rx        (rx),
      .data      (data),
      .load_en   (load_en),
      .busy      (busy),
`ifdef PARITY_CHK_EN
      .parity_err(parity_err),
`endif
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit                is_load;
      logic [DATA_W-1:0] data;
      bit                perr;
   } exp_t;

   exp_t              exp_q[$];
   exp_t              e;
   int                n_cmp = 0;
   int                n_bad = 0;
   logic [DATA_W-1:0] last_good;
   logic              prev_le = 1'b0;
   logic              prev_fe = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every output pulse must match the oldest queued expectation
   always @(posedge clk) begin
      #1;
      if (load_en || frame_err) begin
         check("pulse_exclusive", 32'(load_en & frame_err), 0);
         check("pulse_width", 32'((load_en & prev_le) | (frame_err & prev_fe)), 0);
         if (exp_q.size() == 0) begin
            check("pulse_unexpected", 32'({load_en, frame_err}), 0);
         end else begin
            e = exp_q.pop_front();
            check("load_en", 32'(load_en), 32'(e.is_load));
            check("frame_err", 32'(frame_err), 32'(!e.is_load));
            check("data", 32'(data), 32'(e.data));
            check("busy_at_pulse", 32'(busy), 32'(!e.is_load));
`ifdef PARITY_CHK_EN
            check("parity_err", 32'(parity_err), 32'(e.is_load & e.perr));
`endif
         end
      end
      prev_le = load_en;
      prev_fe = frame_err;
   end

   // One bit with a one-clk tick, then gap idle clks; called at a negedge
   task automatic send_bit(input logic b, input int gap);
      rx   = b;
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   // Full frame; freeze_at >= 0 stalls ticks for 50 clks after that data bit
   task automatic send_frame(input logic [DATA_W-1:0] w, input logic stop,
                             input logic par, input int gap, input int freeze_at);
      exp_t x;
      send_bit(1'b0, gap);
      for (int i = 0; i < int'(DATA_W); i++) begin
         send_bit(w[i], gap);
         if (i == freeze_at) begin
            for (int k = 0; k < 50; k++) begin
               rx = ~rx;
               @(negedge clk);
            end
            check("freeze_busy", 32'(busy), 1);
            check("freeze_data", 32'(data), 32'(last_good));
         end
      end
`ifdef PARITY_CHK_EN
      send_bit(par, gap);
`endif
      x.is_load = stop;
      x.perr    = ^{w, par};
      if (stop) last_good = w;
      x.data = last_good;
      exp_q.push_back(x);
      send_bit(stop, gap);
   endtask

   initial begin
      logic [DATA_W-1:0] w;
      logic              stop;
      logic              par;
      int                gap;

      reset = 1'b1;
      tick  = 1'b0;
      rx    = 1'b1;
      last_good = '0;
      repeat (3) @(negedge clk);
      check("reset_data", 32'(data), 0);
      check("reset_busy", 32'(busy), 0);
      check("reset_load_en", 32'(load_en), 0);
      check("reset_frame_err", 32'(frame_err), 0);
      reset = 1'b0;
      @(negedge clk);

      // Basic word, tick every 4th clk
      send_frame(7'h55, 1'b1, 1'b0, 3, -1);
      repeat (6) @(negedge clk);
      check("t1_busy_after", 32'(busy), 0);
      check("t1_data", 32'(data), 32'h55);

      // Back-to-back, tick every clk
      send_frame(7'h7F, 1'b1, 1'b0, 0, -1);
      send_frame(7'h00, 1'b1, 1'b0, 0, -1);
      repeat (4) @(negedge clk);

      // Bad stop, held-low line, then recovery
      send_frame(7'h2A, 1'b0, 1'b0, 1, -1);
      repeat (20) send_bit(1'b0, 1);
      check("t3_break_busy", 32'(busy), 1);
      send_bit(1'b1, 1);
      send_frame(7'h11, 1'b1, 1'b0, 1, -1);
      repeat (4) @(negedge clk);
      check("t3_data", 32'(data), 32'h11);

      // Reset aborts a frame after 3 data bits of 0x33
      w = 7'h33;
      send_bit(1'b0, 1);
      for (int i = 0; i < 3; i++) send_bit(w[i], 1);
      reset = 1'b1;
      @(negedge clk);
      check("t4_busy", 32'(busy), 0);
      check("t4_data", 32'(data), 0);
      check("t4_load_en", 32'(load_en), 0);
      reset = 1'b0;
      last_good = '0;
      @(negedge clk);
      send_frame(7'h33, 1'b1, 1'b0, 1, -1);

      // Tick stalls mid-frame
      send_frame(7'h5A, 1'b1, 1'b0, 2, 3);
      repeat (4) @(negedge clk);
      check("t5_data", 32'(data), 32'h5A);

`ifdef PARITY_CHK_EN
      send_frame(7'h03, 1'b1, 1'b0, 1, -1);
      send_frame(7'h03, 1'b1, 1'b1, 1, -1);
      repeat (4) @(negedge clk);
`endif

      // Random frames with occasional bad stop bits and idle ticks
      for (int n = 0; n < 40; n++) begin
         w    = DATA_W'($urandom);
         stop = ($urandom_range(0, 7) != 0);
         par  = 1'($urandom);
         gap  = int'($urandom_range(0, 3));
         send_frame(w, stop, par, gap, -1);
         if (!stop) send_bit(1'b1, gap);
         repeat ($urandom_range(0, 2)) send_bit(1'b1, gap);
      end

      repeat (10) @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 0);
      check("final_busy", 32'(busy), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

endmodule
